// File: rtl/horner_poly_fsm_if.sv
// Stream bundle for horner_poly_fsm: sample input (s_*), coefficient load (cf_*), result output (m_*).
interface horner_poly_fsm_if #(
    parameter int W = 32
);
    // Handshake on every channel: a word moves on a rising clk edge where tvalid && tready.
    // The source holds tvalid and payload stable until that edge; tvalid never waits on tready.
    logic         s_tvalid;
    logic         s_tready;
    logic [W-1:0] s_tdata;
    logic         s_tlast;

    logic         cf_tvalid;
    logic         cf_tready;
    logic [W-1:0] cf_tdata;
    logic         cf_tlast;

    logic         m_tvalid;
    logic         m_tready;
    logic [W-1:0] m_tdata;
    logic         m_tlast;
    logic         m_tuser;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast,
        output s_tready,
        input  cf_tvalid, cf_tdata, cf_tlast,
        output cf_tready,
        output m_tvalid, m_tdata, m_tlast, m_tuser,
        input  m_tready
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast,
        input  s_tready,
        output cf_tvalid, cf_tdata, cf_tlast,
        input  cf_tready,
        input  m_tvalid, m_tdata, m_tlast, m_tuser,
        output m_tready
    );
endinterface

// File: rtl/horner_poly_fsm.sv
// Order-N fixed-point polynomial evaluator by Horner's rule, one multiply-accumulate per cycle.
// Define HORNER_SAT_EN for per-step saturation reported on m_tuser; otherwise steps wrap.
module horner_poly_fsm #(
    parameter int ORDER = 3,
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter logic [(ORDER+1)*W-1:0] COEF_INIT =
        {32'h00010000, 32'h00020000, 32'h00038000, 32'h00048000}
) (
    input  logic              clk,
    input  logic              rst,
    horner_poly_fsm_if.slave  bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int              CW        = $clog2(ORDER + 1);
    localparam logic [CW-1:0]   PTR_TOP   = CW'(ORDER);
    localparam logic [CW-1:0]   IDX_START = CW'(ORDER - 1);
    localparam logic [2*W-1:0]  RND       = (2*W)'(1) << (FRAC - 1);
    localparam logic [W-1:0]    Y_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    Y_MIN     = {1'b1, {(W-1){1'b0}}};

    state_t        state, state_nxt;
    logic          load;

    logic [W-1:0]  coef [0:ORDER];
    logic [CW-1:0] ptr;
    logic [CW-1:0] idx;
    logic [W-1:0]  x_q;
    logic [W-1:0]  acc;
    logic          last_q;
    logic          sat_q;

    logic [W-1:0]         coef_sel;
    logic [2*W-1:0]       prod;
    logic [2*W-1:0]       prod_rnd;
    logic signed [2*W-1:0] prod_sh;
    logic [2*W:0]         sum;
    logic                 ovf;
    logic                 step_sat;
    logic [W-1:0]         step_val;

    // Control: a pending coefficient word blocks sample acceptance in IDLE.
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        bus.s_tready  = 1'b0;
        bus.cf_tready = 1'b0;
        bus.m_tvalid  = 1'b0;
        case (state)
            IDLE: begin
                bus.cf_tready = rst;
                bus.s_tready  = rst && !bus.cf_tvalid;
                if (bus.s_tvalid && bus.s_tready) begin
                    load      = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (idx == '0) state_nxt = OUT;
            end
            OUT: begin
                bus.m_tvalid = 1'b1;
                bus.s_tready = bus.m_tready;
                if (bus.m_tready) begin
                    if (bus.s_tvalid) begin
                        load      = 1'b1;
                        state_nxt = ACC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One Horner step: round-half-up the Q-format product, then add the next coefficient.
    always_comb begin
        coef_sel = coef[idx];
        prod     = {{W{acc[W-1]}}, acc} * {{W{x_q[W-1]}}, x_q};
        prod_rnd = prod + RND;
        prod_sh  = $signed(prod_rnd) >>> FRAC;
        sum      = {prod_sh[2*W-1], prod_sh} + {{(W+1){coef_sel[W-1]}}, coef_sel};
        ovf      = !((&sum[2*W:W-1]) || !(|sum[2*W:W-1]));
`ifdef HORNER_SAT_EN
        step_sat = ovf;
        step_val = ovf ? (sum[2*W] ? Y_MIN : Y_MAX) : sum[W-1:0];
`else
        step_sat = 1'b0;
        step_val = sum[W-1:0];
`endif
    end

`ifndef HORNER_SAT_EN
    logic ovf_unused;
    assign ovf_unused = ovf ^ Y_MAX[0] ^ Y_MIN[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            last_q <= 1'b0;
            sat_q  <= 1'b0;
            ptr    <= PTR_TOP;
            for (int i = 0; i <= ORDER; i++) coef[i] <= COEF_INIT[i*W +: W];
        end else begin
            if (load) begin
                x_q    <= bus.s_tdata;
                last_q <= bus.s_tlast;
                acc    <= coef[ORDER];
                idx    <= IDX_START;
                sat_q  <= 1'b0;
            end else if (state == ACC) begin
                acc   <= step_val;
                sat_q <= sat_q | step_sat;
                idx   <= idx - 1'b1;
            end
            // cf_tready is only high in IDLE, so the coefficient set is frozen during a sample.
            if (bus.cf_tvalid && bus.cf_tready) begin
                coef[ptr] <= bus.cf_tdata;
                ptr       <= (bus.cf_tlast || ptr == '0) ? PTR_TOP : ptr - 1'b1;
            end
        end
    end

    assign bus.m_tdata = acc;
    assign bus.m_tlast = last_q;
    assign bus.m_tuser = sat_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_horner_poly_fsm.sv
// Self-checking bench for horner_poly_fsm: directed spec cases plus randomized samples vs a Horner model.
module tb_horner_poly_fsm;
  localparam int ORDER = 3;
  localparam int W     = 32;
  localparam int FRAC  = 16;
  localparam int EW    = W + 2;
  localparam int BOUND = 200;
  localparam logic [(ORDER+1)*W-1:0] COEF_INIT =
    {32'h00010000, 32'h00020000, 32'h00038000, 32'h00048000};
  localparam longint RND  = 64'sd1 <<< (FRAC - 1);
  localparam longint YMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint YMIN = -(64'sd1 <<< (W - 1));

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  horner_poly_fsm_if #(.W(W)) bus ();

  horner_poly_fsm #(.ORDER(ORDER), .W(W), .FRAC(FRAC), .COEF_INIT(COEF_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---- clock / cycle counter / watchdog ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model: coefficient store and Horner evaluation ----
  logic [W-1:0] mc [0:ORDER];
  int           mptr;
  logic [EW-1:0] exp_q[$];   // {user, last, data}

  task automatic model_reset();
    for (int i = 0; i <= ORDER; i++) mc[i] = COEF_INIT[i*W +: W];
    mptr = ORDER;
  endtask

  function automatic logic [W:0] model_eval(input logic [W-1:0] x);
    longint       a, p, s;
    logic         sat;
    logic [W-1:0] t;
    a   = longint'($signed(mc[ORDER]));
    sat = 1'b0;
    for (int i = ORDER - 1; i >= 0; i--) begin
      p = a * longint'($signed(x));
      p = (p + RND) >>> FRAC;
      s = p + longint'($signed(mc[i]));
`ifdef HORNER_SAT_EN
      if (s > YMAX) begin s = YMAX; sat = 1'b1; end
      else if (s < YMIN) begin s = YMIN; sat = 1'b1; end
`else
      t = s[W-1:0];
      s = longint'($signed(t));
`endif
      a = s;
    end
    t = a[W-1:0];
    return {sat, t};
  endfunction

  // ---- driver tasks ----
  task automatic send_sample(input logic [W-1:0] x, input logic last, output int hs_cyc);
    int           n;
    logic [W:0]   r;
    n = 0;
    bus.s_tdata  = x;
    bus.s_tlast  = last;
    bus.s_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_tready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_handshake: s_tready never rose within %0d cycles (x=%h)", BOUND, x);
      bus.s_tvalid = 1'b0;
      hs_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    bus.s_tvalid = 1'b0;
    r = model_eval(x);
    exp_q.push_back({r[W], last, r[W-1:0]});
  endtask

  task automatic load_coef(input logic [W-1:0] word, input logic last);
    int n;
    n = 0;
    bus.cf_tdata  = word;
    bus.cf_tlast  = last;
    bus.cf_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.cf_tready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cf_tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cf_handshake: cf_tready never rose within %0d cycles", BOUND);
      bus.cf_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cf_tvalid = 1'b0;
    mc[mptr] = word;
    mptr = (last || mptr == 0) ? ORDER : mptr - 1;
  endtask

  // Waits for m_tvalid, records the result, then completes the handshake with m_tready=1.
  task automatic wait_result(output logic [EW-1:0] obs, output int v_cyc, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    obs = '0;
    v_cyc = -1;
    @(negedge clk);
    while (!bus.m_tvalid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.m_tvalid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL m_handshake: m_tvalid never rose within %0d cycles", BOUND);
      ok = 1'b0;
      return;
    end
    v_cyc = cyc;
    obs = {bus.m_tuser, bus.m_tlast, bus.m_tdata};
    bus.m_tready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.s_tready, bus.cf_tready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got {s,cf}=%b want 00", {bus.s_tready, bus.cf_tready});
    end
    n_cmp++;
    if ({bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata} !== {3'b000, {W{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_m: got valid=%b last=%b user=%b data=%h want all 0",
               bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata);
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.s_tready, bus.cf_tready} !== 2'b11) begin
      n_bad++;
      $display("FAIL release_ready: got {s,cf}=%b want 11", {bus.s_tready, bus.cf_tready});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  xs   [4];
    logic          ls   [4];
    logic [EW-1:0] want [4];
    logic [EW-1:0] obs, e;
    int            hs, vc;
    bit            ok;
    xs[0] = 32'h00020000; ls[0] = 1'b0; want[0] = {2'b00, 32'h001B8000};
    xs[1] = 32'hFFFF0000; ls[1] = 1'b0; want[1] = {2'b00, 32'h00020000};
    xs[2] = 32'h000A0000; ls[2] = 1'b1; want[2] = {2'b01, 32'h04D78000};
    xs[3] = 32'h00640000; ls[3] = 1'b0; want[3] = {2'b10, 32'h7FFFFFFF};
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_sample(xs[i], ls[i], hs);
      wait_result(obs, vc, ok);
      e = exp_q.pop_front();
`ifndef HORNER_SAT_EN
      if (i == 3) want[3] = e;
`endif
      if (ok) begin
        n_cmp++;
        if (obs !== want[i]) begin
          n_bad++;
          $display("FAIL directed_%0d: x=%h got {user,last,data}=%h want %h", i, xs[i], obs, want[i]);
        end
        n_cmp++;
        if (vc - hs !== ORDER) begin
          n_bad++;
          $display("FAIL latency_%0d: got %0d cycles want %0d", i, vc - hs, ORDER);
        end
      end
    end
  endtask

  task automatic test_coef_load();
    logic [EW-1:0] obs;
    int            hs, vc;
    bit            ok;
    bus.m_tready = 1'b1;
    load_coef(32'h00000000, 1'b0);
    load_coef(32'h00000000, 1'b0);
    load_coef(32'h00010000, 1'b0);
    load_coef(32'h00000000, 1'b1);
    send_sample(32'h00030000, 1'b0, hs);
    wait_result(obs, vc, ok);
    void'(exp_q.pop_front());
    if (ok) begin
      n_cmp++;
      if (obs !== {2'b00, 32'h00030000}) begin
        n_bad++;
        $display("FAIL coef_identity: got %h want %h", obs, {2'b00, 32'h00030000});
      end
    end
    // cf and s together in IDLE: the coefficient (c[N]=1.0) must land before x=2.0 is taken
    bus.cf_tdata  = 32'h00010000;
    bus.cf_tlast  = 1'b1;
    bus.cf_tvalid = 1'b1;
    bus.s_tdata   = 32'h00020000;
    bus.s_tlast   = 1'b0;
    bus.s_tvalid  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.s_tready, bus.cf_tready} !== 2'b01) begin
      n_bad++;
      $display("FAIL collision_ready: got {s,cf}=%b want 01", {bus.s_tready, bus.cf_tready});
    end
    @(posedge clk);
    #1;
    bus.cf_tvalid = 1'b0;
    mc[mptr] = 32'h00010000;
    mptr = ORDER;
    send_sample(32'h00020000, 1'b0, hs);
    wait_result(obs, vc, ok);
    void'(exp_q.pop_front());
    if (ok) begin
      n_cmp++;
      if (obs !== {2'b00, 32'h000A0000}) begin
        n_bad++;
        $display("FAIL collision_result: got %h want %h", obs, {2'b00, 32'h000A0000});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] held, obs, e;
    logic [W-1:0]  x1, x2;
    int            hs, vc, n;
    bit            ok;
    x1 = $urandom_range(0, 32'h00060000) - 32'h00030000;
    x2 = $urandom_range(0, 32'h00060000) - 32'h00030000;
    bus.m_tready = 1'b0;
    send_sample(x1, 1'($urandom_range(0, 1)), hs);
    n = 0;
    @(negedge clk);
    while (!bus.m_tvalid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    held = {bus.m_tuser, bus.m_tlast, bus.m_tdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (!bus.m_tvalid || held !== e) begin
      n_bad++;
      $display("FAIL bp_result: valid=%b got %h want %h", bus.m_tvalid, held, e);
    end
    bus.s_tdata  = x2;
    bus.s_tlast  = 1'b1;
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {bus.m_tuser, bus.m_tlast, bus.m_tdata};
      n_cmp++;
      if (bus.m_tvalid !== 1'b1 || obs !== held || bus.s_tready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: valid=%b data=%h want %h s_tready=%b want 0",
                 i, bus.m_tvalid, obs, held, bus.s_tready);
      end
    end
    bus.m_tready = 1'b1;
    #1;
    n_cmp++;
    if (bus.s_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready: got s_tready=%b want 1", bus.s_tready);
    end
    @(posedge clk);
    #1;
    hs = cyc;
    bus.s_tvalid = 1'b0;
    begin
      logic [W:0] r;
      r = model_eval(x2);
      exp_q.push_back({r[W], 1'b1, r[W-1:0]});
    end
    wait_result(obs, vc, ok);
    e = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL bp_next_result: got %h want %h", obs, e);
      end
      n_cmp++;
      if (vc - hs !== ORDER) begin
        n_bad++;
        $display("FAIL bp_next_latency: got %0d want %0d", vc - hs, ORDER);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NS = 8;
    for (int i = 0; i <= ORDER; i++)
      load_coef($urandom_range(0, 32'h00080000) - 32'h00040000, i == ORDER);
    bus.m_tready = 1'b1;
    fork
      begin
        int hs;
        for (int i = 0; i < NS; i++)
          send_sample($urandom_range(0, 32'h00080000) - 32'h00040000,
                      1'($urandom_range(0, 1)), hs);
      end
      begin
        logic [EW-1:0] obs, e;
        int            vc, prev;
        bit            ok;
        prev = -1;
        for (int i = 0; i < NS; i++) begin
          wait_result(obs, vc, ok);
          if (!ok) break;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_result_%0d: got %h but no result expected", i, obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              n_bad++;
              $display("FAIL b2b_result_%0d: got %h want %h", i, obs, e);
            end
          end
          if (prev >= 0) begin
            n_cmp++;
            if (vc - prev !== ORDER + 1) begin
              n_bad++;
              $display("FAIL b2b_interval_%0d: got %0d want %0d", i, vc - prev, ORDER + 1);
            end
          end
          prev = vc;
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] obs;
    int            hs, vc, n;
    bit            ok;
    // reset while in ACC
    bus.m_tready = 1'b0;
    send_sample(32'h00020000, 1'b0, hs);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_tvalid, bus.s_tready} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_acc: got {m_tvalid,s_tready}=%b want 00", {bus.m_tvalid, bus.s_tready});
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    // reset while holding a result in OUT
    for (int i = 0; i <= ORDER; i++) load_coef(32'h00010000, i == ORDER);
    send_sample(32'h00010000, 1'b1, hs);
    n = 0;
    @(negedge clk);
    while (!bus.m_tvalid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_tvalid, bus.m_tlast} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_out: got {m_tvalid,m_tlast}=%b want 00", {bus.m_tvalid, bus.m_tlast});
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus.m_tready = 1'b1;
    send_sample(32'h00020000, 1'b0, hs);
    wait_result(obs, vc, ok);
    void'(exp_q.pop_front());
    if (ok) begin
      n_cmp++;
      if (obs !== {2'b00, 32'h001B8000}) begin
        n_bad++;
        $display("FAIL rst_coef_restore: got %h want %h", obs, {2'b00, 32'h001B8000});
      end
    end
  endtask

  // ---- main sequence and report ----
  initial begin
    bus.s_tvalid  = 1'b0;
    bus.s_tdata   = '0;
    bus.s_tlast   = 1'b0;
    bus.cf_tvalid = 1'b0;
    bus.cf_tdata  = '0;
    bus.cf_tlast  = 1'b0;
    bus.m_tready  = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_coef_load();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || bus.m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, m_tvalid=%b want 0 and 0",
               exp_q.size(), bus.m_tvalid);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
